// File: rtl/send_ctrl_pkg.sv
// Shared types and default sizing for the burst send controller.
package send_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_t;

  localparam int unsigned DEF_BURST_LEN   = 8;
  localparam int unsigned DEF_DELAY_CYC   = 400;
  localparam int unsigned DEF_TIMEOUT_CYC = 10000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // A one-byte burst still needs a 1-bit index port.
  function automatic int unsigned idx_width(input int unsigned len);
    return (len > 1) ? int'($clog2(len)) : 1;
  endfunction

endpackage

// File: rtl/cyc_timer.sv
// Saturating dwell counter: cleared by load, counts while enabled, flags term.
module cyc_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc_c
);

  logic [W-1:0] count;

  // Saturate at all-ones so a long dwell can never wrap back under term.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

  assign tc_c = (count == term);

endmodule

// File: rtl/burst_send_ctrl.sv
// Sequences fixed-length byte bursts to a UART transmitter, one-shot or
// continuous with an idle gap, with stop handling and a per-byte timeout.
module burst_send_ctrl
  import send_ctrl_pkg::*;
#(
  parameter int unsigned BURST_LEN   = DEF_BURST_LEN,
  parameter int unsigned DELAY_CYC   = DEF_DELAY_CYC,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 stop,
  input  logic                                 mode,
  input  logic                                 tx_done,
  output logic                                 tx_en,
  output logic [idx_width(BURST_LEN)-1:0]      byte_idx,
  output logic                                 busy,
  output logic                                 burst_done,
  output logic                                 err
);

  localparam int unsigned IDX_W    = idx_width(BURST_LEN);
  localparam int unsigned TMR_W    = $clog2(max_u(DELAY_CYC, TIMEOUT_CYC) + 1);
  localparam int unsigned GAP_TERM = DELAY_CYC - 1;
  // The SEND cycle carrying tx_en counts toward the byte's timeout budget.
  localparam int unsigned TO_TERM  = (TIMEOUT_CYC >= 2) ? TIMEOUT_CYC - 2 : 0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

  state_t             state;
  state_t             next_state;
  logic               mode_q;
  logic               mode_d;
  logic               pend_q;
  logic               pend_d;
  logic [IDX_W-1:0]   idx_d;
  logic               err_d;
  logic               done_d;
  logic               stop_any;
  logic               last_byte;
  logic               tmr_load;
  logic               tmr_en;
  logic [TMR_W-1:0]   tmr_term;
  logic               tmr_tc_c;

  assign stop_any  = stop | pend_q;
  assign last_byte = (byte_idx == LAST_IDX);

  // Dwell timer restarts on every state change; only GAP and WAIT_DONE use it.
  assign tmr_load = (next_state != state);
  assign tmr_en   = (state == ST_GAP) || (state == ST_WAIT_DONE);
  assign tmr_term = (state == ST_GAP) ? TMR_W'(GAP_TERM) : TMR_W'(TO_TERM);

  cyc_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .en    (tmr_en),
    .term  (tmr_term),
    .tc_c  (tmr_tc_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    next_state = state;
    mode_d     = mode_q;
    pend_d     = pend_q;
    idx_d      = byte_idx;
    err_d      = err;
    done_d     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          if (err) begin
            err_d = 1'b0;
          end else begin
            next_state = ST_SEND;
            mode_d     = mode;
            idx_d      = '0;
          end
        end
      end

      ST_SEND: begin
        next_state = ST_WAIT_DONE;
      end

      ST_WAIT_DONE: begin
        if (tx_done) begin
          if (!last_byte) begin
            if (stop_any) begin
              next_state = ST_IDLE;
              idx_d      = '0;
            end else begin
              next_state = ST_SEND;
              idx_d      = byte_idx + IDX_W'(1);
            end
          end else begin
            done_d     = 1'b1;
            idx_d      = '0;
            next_state = (mode_q && !stop_any) ? ST_GAP : ST_IDLE;
          end
        end else if (tmr_tc_c) begin
          err_d      = 1'b1;
          idx_d      = '0;
          next_state = ST_IDLE;
        end
      end

      ST_GAP: begin
        if (stop_any) begin
          next_state = ST_IDLE;
        end else if (tmr_tc_c) begin
          next_state = ST_SEND;
        end
      end

      default: begin
        next_state = ST_IDLE;
      end
    endcase

    // A stop seen while busy is held until the FSM lands back in IDLE.
    if ((state != ST_IDLE) && stop) begin
      pend_d = 1'b1;
    end
    if (next_state == ST_IDLE) begin
      pend_d = 1'b0;
    end
  end

  // Registered outputs and datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q     <= 1'b0;
      pend_q     <= 1'b0;
      byte_idx   <= '0;
      err        <= 1'b0;
      burst_done <= 1'b0;
      tx_en      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      pend_q     <= pend_d;
      byte_idx   <= idx_d;
      err        <= err_d;
      burst_done <= done_d;
      tx_en      <= (next_state == ST_SEND);
      busy       <= (next_state != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_burst_send_ctrl.sv
// Scoreboard bench for burst_send_ctrl: expected tx_en/burst_done events are
// queued with their cycle numbers and matched as the DUT produces them.
module tb_burst_send_ctrl;

  localparam int unsigned BL  = 4;
  localparam int unsigned DC  = 10;
  localparam int unsigned TC  = 50;
  localparam int          RSP = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       mode;
  logic       tx_done;
  logic       rsp_done = 1'b0;
  logic       stray_done;
  logic       rsp_en = 1'b1;
  logic       tx_en;
  logic [1:0] byte_idx;
  logic       busy;
  logic       burst_done;
  logic       err;

  int cyc     = 0;
  int done_at = -1;
  int n_tests = 0;
  int n_fail  = 0;
  int k;

  typedef struct {
    int cyc;
    int idx;
  } tx_exp_t;

  tx_exp_t tx_q[$];
  int      bd_q[$];

  assign tx_done = rsp_done | stray_done;

  burst_send_ctrl #(
    .BURST_LEN   (BL),
    .DELAY_CYC   (DC),
    .TIMEOUT_CYC (TC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .tx_done    (tx_done),
    .tx_en      (tx_en),
    .byte_idx   (byte_idx),
    .busy       (busy),
    .burst_done (burst_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor plus UART responder; samples mid-cycle on the falling edge.
  always @(negedge clk) begin : mon
    tx_exp_t e;
    rsp_done = (cyc == done_at);
    if (tx_en) begin
      if (rsp_en) done_at = cyc + RSP;
      if (tx_q.size() == 0) begin
        check("tx_en_unexpected", tx_q.size(), 1);
      end else begin
        e = tx_q.pop_front();
        check("tx_en_cycle", cyc, e.cyc);
        check("byte_idx", int'(byte_idx), e.idx);
      end
    end
    if (burst_done) begin
      if (bd_q.size() == 0) begin
        check("burst_done_unexpected", bd_q.size(), 1);
      end else begin
        check("burst_done_cycle", cyc, bd_q.pop_front());
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic m, input logic with_stop);
    int c0;
    c0    = cyc;
    start = 1'b1;
    mode  = m;
    stop  = with_stop;
    goto(c0 + 1);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // One full burst with the responder echoing tx_done RSP cycles after tx_en.
  task automatic expect_burst(input int first);
    for (int i = 0; i < int'(BL); i++) begin
      tx_q.push_back('{first + i * (RSP + 1), i});
    end
    bd_q.push_back(first + int'(BL) * (RSP + 1));
  endtask

  task automatic scb_drained(input string tag);
    check({tag, "_txq_left"}, tx_q.size(), 0);
    check({tag, "_bdq_left"}, bd_q.size(), 0);
  endtask

  function automatic int outs();
    return int'({tx_en, busy, burst_done, err, byte_idx});
  endfunction

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time bound, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    mode       = 1'b0;
    stray_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs(), 0);
    rst_n = 1'b1;
    goto(cyc + 2);

    // One-shot burst
    k = cyc;
    expect_burst(k + 1);
    pulse_start(1'b0, 1'b0);
    check("oneshot_busy", int'(busy), 1);
    goto(k + 26);
    check("oneshot_idle", int'(busy), 0);
    scb_drained("oneshot");

    // Continuous: three bursts, then stop during the third gap
    k = cyc;
    expect_burst(k + 1);
    expect_burst(k + 1 + 34);
    expect_burst(k + 1 + 68);
    pulse_start(1'b1, 1'b0);
    goto(k + 94);
    check("gap_busy", int'(busy), 1);
    goto(k + 95);
    stop = 1'b1;
    goto(k + 96);
    stop = 1'b0;
    check("gap_stop_idle", int'(busy), 0);
    goto(k + 110);
    scb_drained("continuous");

    // Stop while byte 1 is in flight
    k = cyc;
    tx_q.push_back('{k + 1, 0});
    tx_q.push_back('{k + 7, 1});
    pulse_start(1'b0, 1'b0);
    goto(k + 8);
    check("stop_mid_idx", int'(byte_idx), 1);
    stop = 1'b1;
    goto(k + 9);
    stop = 1'b0;
    goto(k + 12);
    check("stop_mid_waiting", int'(busy), 1);
    goto(k + 13);
    check("stop_mid_idle", int'(busy), 0);
    goto(k + 40);
    scb_drained("stop_mid");

    // Start and stop together: nothing starts
    k = cyc;
    pulse_start(1'b0, 1'b1);
    goto(k + 3);
    check("start_stop_busy", int'(busy), 0);
    scb_drained("start_stop");

    // Timeout with tx_done withheld
    rsp_en = 1'b0;
    k = cyc;
    tx_q.push_back('{k + 1, 0});
    pulse_start(1'b0, 1'b0);
    goto(k + 50);
    check("timeout_err_early", int'(err), 0);
    check("timeout_busy_early", int'(busy), 1);
    goto(k + 51);
    check("timeout_err", int'(err), 1);
    check("timeout_idle", int'(busy), 0);
    check("timeout_idx", int'(byte_idx), 0);
    goto(k + 55);
    k = cyc;
    pulse_start(1'b0, 1'b0);
    check("err_cleared", int'(err), 0);
    check("err_clear_no_burst", int'(busy), 0);
    goto(k + 3);
    check("err_clear_still_idle", int'(busy), 0);
    rsp_en = 1'b1;
    k = cyc;
    expect_burst(k + 1);
    pulse_start(1'b0, 1'b0);
    goto(k + 30);
    check("post_err_idle", int'(busy), 0);
    check("post_err_err", int'(err), 0);
    scb_drained("timeout");

    // Reset during GAP, then a stray tx_done
    k = cyc;
    expect_burst(k + 1);
    pulse_start(1'b1, 1'b0);
    goto(k + 28);
    check("rst_gap_busy", int'(busy), 1);
    rst_n = 1'b0;
    goto(k + 29);
    check("rst_gap_outputs", outs(), 0);
    rst_n = 1'b1;
    goto(k + 31);
    stray_done = 1'b1;
    goto(k + 32);
    stray_done = 1'b0;
    goto(k + 35);
    check("stray_done_idle", int'(busy), 0);
    scb_drained("rst_gap");

    // Reset during WAIT_DONE; the late tx_done lands in IDLE
    k = cyc;
    tx_q.push_back('{k + 1, 0});
    pulse_start(1'b1, 1'b0);
    goto(k + 3);
    rst_n = 1'b0;
    goto(k + 4);
    check("rst_wait_outputs", outs(), 0);
    rst_n = 1'b1;
    goto(k + 15);
    check("rst_wait_idle", int'(busy), 0);
    scb_drained("rst_wait");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_send_ctrl.md
BURST_SEND_CTRL -- requirements
Module: burst_send_ctrl

Interface
REQ-001 SHALL have parameter BURST_LEN, default 8, bytes per burst (range 1..256).
REQ-002 SHALL have parameter DELAY_CYC, default 400, idle cycles between bursts in continuous mode (range 1..65535).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 10000, maximum cycles to wait for tx_done per byte.
REQ-004 SHALL have port: clk  input  1  system clock; the single clock, all logic on its rising edge.
REQ-005 SHALL have port: rst_n  input  1  reset; synchronous and active-low.
REQ-006 SHALL have port: start  input  1  level; sampled in IDLE, begins a burst.
REQ-007 SHALL have port: stop  input  1  level; requests halt at the next byte boundary.
REQ-008 SHALL have port: mode  input  1  0 = one-shot burst, 1 = continuous bursts; sampled on leaving IDLE.
REQ-009 SHALL have port: tx_done  input  1  one-cycle pulse from the UART transmitter when a byte completes.
REQ-010 SHALL have port: tx_en  output  1  one-cycle pulse commanding transmission of byte byte_idx.
REQ-011 SHALL have port: byte_idx  output  $clog2(BURST_LEN) (min 1)  index of the byte being sent.
REQ-012 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port: burst_done  output  1  one-cycle pulse after the last byte's tx_done.
REQ-014 SHALL have port: err  output  1  sticky timeout flag.

Function
REQ-015 SHALL implement states IDLE, SEND, WAIT_DONE and GAP.
REQ-016 IDLE: if start=1, stop=0 and err=0, SHALL latch mode, clear byte_idx and go to SEND.
REQ-017 SEND: SHALL assert tx_en for exactly that one cycle, then go to WAIT_DONE; tx_en is registered and high only while in SEND.
REQ-018 Latency: tx_en SHALL rise exactly one cycle after the cycle in which start is sampled high in IDLE.
REQ-019 WAIT_DONE on tx_done with byte_idx < BURST_LEN-1 SHALL increment byte_idx and go to SEND, so the next tx_en is 1 cycle after tx_done.
REQ-020 WAIT_DONE on tx_done with byte_idx = BURST_LEN-1 SHALL pulse burst_done in the next cycle, reset byte_idx to 0, and go to GAP if latched mode=1 and no stop is pending, else to IDLE.
REQ-021 GAP SHALL last exactly DELAY_CYC cycles, then go to SEND, so the first tx_en of the next burst is DELAY_CYC+1 cycles after the last tx_done.
REQ-022 stop=1 in any busy state SHALL set a pending-stop flag; the current byte completes, then the FSM SHALL return to IDLE instead of SEND or GAP; if in GAP, it returns to IDLE on the next cycle.
REQ-023 When start and stop are high together in IDLE, stop SHALL win and no burst starts.
REQ-024 tx_done outside WAIT_DONE SHALL be ignored.
REQ-025 A WAIT_DONE dwell of TIMEOUT_CYC cycles without tx_done SHALL set err, clear byte_idx and go to IDLE with no burst_done pulse.
REQ-026 err SHALL block new bursts until cleared; a start pulse in IDLE with stop=0 clears err without starting a burst.
REQ-027 The gap/timeout counter SHALL be wide enough for max(DELAY_CYC, TIMEOUT_CYC), SHALL clear on every state change, and SHALL never wrap.
REQ-028 BURST_LEN=1 SHALL be supported, with byte_idx constantly 0.

Reset
REQ-029 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE; tx_en, busy, burst_done and err SHALL be 0; byte_idx, the counter and pending-stop SHALL be 0.
REQ-030 Reset asserted mid-burst SHALL abort immediately, with no further tx_en or burst_done.

Structure
REQ-031 Package send_ctrl_pkg SHALL hold the state enum and default parameter constants.
REQ-032 The gap/timeout counter SHALL be a sub-module cyc_timer (load, enable, terminal-count output).

Verification (BURST_LEN=4, DELAY_CYC=10, TIMEOUT_CYC=50; tx_done returned 5 cycles after each tx_en unless stated)
REQ-033 One-shot: mode=0, start pulse -> 4 tx_en pulses with byte_idx 0,1,2,3; burst_done 1 cycle after the 4th tx_done; then busy=0.
REQ-034 Continuous: mode=1 -> next burst's tx_en at exactly 11 cycles after the 4th tx_done, repeating indefinitely.
REQ-035 Stop mid-burst: stop at byte_idx=1 -> byte 1 completes, no further tx_en, IDLE with no burst_done; start+stop together -> nothing happens.
REQ-036 Timeout: tx_done withheld -> err=1 at 50 cycles after tx_en, FSM in IDLE; next start clears err only; the following start runs a burst.
REQ-037 Reset during GAP and during WAIT_DONE -> all outputs 0 on the next edge; a stray tx_done is ignored.
